plab2_proc_dmem_responder: RTL and testbench
============================================

PLAB2_PROC_DMEM_RESPONDER -- requirements
Module: plab2_proc_dmem_responder

Interface
REQ-001 SHALL have parameter p_num_entries, default 256: number of 32-bit words stored; power of two, 16..4096.
REQ-002 SHALL have parameter p_latency, default 0: extra wait cycles before response; range 0..7.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port memreq_val, input, 1: request valid.
REQ-006 SHALL have port memreq_rdy, output, 1: request ready.
REQ-007 SHALL have port memreq_msg_type, input, 1: 0 = read, 1 = write.
REQ-008 SHALL have port memreq_msg_addr, input, 32: byte address.
REQ-009 SHALL have port memreq_msg_data, input, 32: write data.
REQ-010 SHALL have port memresp_val, output, 1: response valid.
REQ-011 SHALL have port memresp_rdy, input, 1: response ready.
REQ-012 SHALL have port memresp_msg_type, output, 1: echo of request type.
REQ-013 SHALL have port memresp_msg_data, output, 32: read data; 0 for writes.
REQ-014 SHALL have port memresp_msg_err, output, 1: error flag (see Configuration).

Function
REQ-015 SHALL implement an FSM with states IDLE, WAIT, RESP; one request outstanding at most.
REQ-016 Handshake: transfer occurs on any cycle with val && rdy; val SHALL NOT depend combinationally on rdy.
REQ-017 memreq_rdy SHALL be 1 only in IDLE.
REQ-018 IDLE + request fire: p_latency == 0 -> RESP; else -> WAIT with counter loaded to p_latency-1.
REQ-019 WAIT: counter decrements each cycle; at counter == 0 -> RESP.
REQ-020 RESP: memresp_val = 1; stays in RESP with response held stable until memresp_rdy; on fire -> IDLE.
REQ-021 Latency: memresp_val SHALL rise exactly p_latency+1 cycles after the request-fire edge.
REQ-022 Word index = memreq_msg_addr[log2(p_num_entries)+1:2]; higher address bits ignored (aliasing wrap-around).
REQ-023 Write: array updated at the request-fire edge; memresp_msg_data = 0.
REQ-024 Read: data registered at the request-fire edge from the array state before that edge; held until the response fires.
REQ-025 Back-to-back: request accepted no earlier than the cycle after the response fires; a read following a write to the same word SHALL return the new data.
REQ-026 memresp_msg_type SHALL equal the accepted request type.

Reset
REQ-027 Reset SHALL force IDLE, counter 0, memresp_val 0, memresp_msg_type 0, memresp_msg_data 0, memresp_msg_err 0; memreq_rdy SHALL be 1 in the first cycle after reset deasserts.
REQ-028 Array contents SHALL NOT be reset; a write committed before reset SHALL persist.
REQ-029 Reset in WAIT or RESP SHALL drop the pending response; no response for it SHALL appear after reset.

Configuration
REQ-030 Macro PLAB2_PROC_DMEM_RESPONDER_ERR_EN defined: a request with addr[1:0] != 0 or any address bit above the index range set SHALL get memresp_msg_err = 1 and memresp_msg_data = 0; a write with such an address SHALL NOT modify the array; latency is unchanged.
REQ-031 Macro PLAB2_PROC_DMEM_RESPONDER_ERR_EN not defined: memresp_msg_err SHALL be tied 0; addr[1:0] and the upper address bits are ignored per REQ-022.

Verification
REQ-032 p_latency=0: write 0xdeadbeef to 0x1000, then read 0x1000 -> each response valid 1 cycle after fire; read returns 0xdeadbeef; write response data 0.
REQ-033 p_latency=3: read fired at cycle t -> memresp_val first high at t+4; memreq_rdy low at t+1..t+4.
REQ-034 Response backpressure: memresp_rdy held 0 for 5 cycles -> memresp_val and data stable; memreq_rdy stays 0; IDLE entered the cycle after fire.
REQ-035 p_num_entries=256: write 0x11 to 0x0004, read 0x0404 -> 0x11 without ERR_EN; err=1 and data 0 with ERR_EN.
REQ-036 Reset asserted in WAIT (p_latency=5) -> no memresp_val after reset; next request behaves normally.
REQ-037 Random val/rdy stress against a reference word-array model -> all responses match in order, no lost or duplicated responses.

Source files
------------

// File: rtl/plab2_proc_dmem_responder.sv
// plab2_proc_dmem_responder
// Word-addressed data memory that answers one val/rdy request at a time.
// Each response arrives p_latency+1 cycles after the request is accepted
// and is held until the consumer takes it.
//
// Parameters:
//   p_num_entries : number of 32-bit words (power of two, 16..4096)
//   p_latency     : extra wait cycles before the response (0..7)
//
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   memreq_val / memreq_rdy         : request handshake
//   memreq_msg_type                 : 0 = read, 1 = write
//   memreq_msg_addr                 : byte address
//   memreq_msg_data                 : write data
//   memresp_val / memresp_rdy       : response handshake
//   memresp_msg_type                : echo of the accepted request type
//   memresp_msg_data                : read data (0 for writes and errors)
//   memresp_msg_err                 : address error flag
//
// Optional feature: define PLAB2_PROC_DMEM_RESPONDER_ERR_EN to flag
// misaligned or out-of-range addresses; otherwise the error flag is 0 and
// those address bits are ignored (the word index wraps around).
module plab2_proc_dmem_responder #(
    parameter int unsigned p_num_entries = 256,
    parameter int unsigned p_latency     = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memreq_val,
    output logic        memreq_rdy,
    input  logic        memreq_msg_type,
    input  logic [31:0] memreq_msg_addr,
    input  logic [31:0] memreq_msg_data,
    output logic        memresp_val,
    input  logic        memresp_rdy,
    output logic        memresp_msg_type,
    output logic [31:0] memresp_msg_data,
    output logic        memresp_msg_err
);

    localparam int unsigned c_idx_w  = $clog2(p_num_entries);
    localparam int unsigned c_cnt_w  = 3;
    localparam int unsigned c_data_w = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic                 req_fire_c;
    logic                 addr_err_c;
    logic                 wr_en_c;
    logic [c_idx_w-1:0]   idx_c;

    logic                 rdy_q;
    logic                 val_q;
    logic                 type_q;
    logic                 err_q;
    logic [c_data_w-1:0]  data_q;

    logic [c_data_w-1:0]  mem [p_num_entries];

    assign idx_c = memreq_msg_addr[c_idx_w+1:2];

`ifdef PLAB2_PROC_DMEM_RESPONDER_ERR_EN
    // Misaligned, or any bit above the index range set.
    assign addr_err_c = (memreq_msg_addr[1:0] != 2'b00) ||
                        (memreq_msg_addr[31:c_idx_w+2] != '0);
`else
    logic unused_addr_bits_c;
    assign addr_err_c         = 1'b0;
    assign unused_addr_bits_c = ^{memreq_msg_addr[31:c_idx_w+2], memreq_msg_addr[1:0]};
`endif

    // Next-state logic; the latency counter only runs in WAIT.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_fire_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (memreq_val) begin
                    req_fire_c = 1'b1;
                    if (p_latency == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = c_cnt_w'(p_latency - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - c_cnt_w'(1);
                end
            end
            RESP: begin
                if (memresp_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, handshake flags and the held response payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdy_q   <= 1'b1;
            val_q   <= 1'b0;
            type_q  <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= (state_d == IDLE);
            val_q   <= (state_d == RESP);
            if (req_fire_c) begin
                type_q <= memreq_msg_type;
                err_q  <= addr_err_c;
                // Non-blocking read sees the array as it was before this edge.
                data_q <= (memreq_msg_type || addr_err_c) ? '0 : mem[idx_c];
            end
        end
    end

    assign wr_en_c = !reset && req_fire_c && memreq_msg_type && !addr_err_c;

    // Storage array; deliberately not reset so contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[idx_c] <= memreq_msg_data;
        end
    end

    assign memreq_rdy       = rdy_q;
    assign memresp_val      = val_q;
    assign memresp_msg_type = type_q;
    assign memresp_msg_data = data_q;
    assign memresp_msg_err  = err_q;

endmodule

// File: tb/tb_plab2_proc_dmem_responder.sv
// Self-checking bench for plab2_proc_dmem_responder (256 words, latency 3).
module tb_plab2_proc_dmem_responder;

    localparam int unsigned N   = 256;
    localparam int unsigned LAT = 3;

    logic        clk;
    logic        reset;
    logic        memreq_val;
    logic        memreq_rdy;
    logic        memreq_msg_type;
    logic [31:0] memreq_msg_addr;
    logic [31:0] memreq_msg_data;
    logic        memresp_val;
    logic        memresp_rdy;
    logic        memresp_msg_type;
    logic [31:0] memresp_msg_data;
    logic        memresp_msg_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [int];
    int          written [$];

    plab2_proc_dmem_responder #(
        .p_num_entries(N),
        .p_latency    (LAT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .memreq_val      (memreq_val),
        .memreq_rdy      (memreq_rdy),
        .memreq_msg_type (memreq_msg_type),
        .memreq_msg_addr (memreq_msg_addr),
        .memreq_msg_data (memreq_msg_data),
        .memresp_val     (memresp_val),
        .memresp_rdy     (memresp_rdy),
        .memresp_msg_type(memresp_msg_type),
        .memresp_msg_data(memresp_msg_data),
        .memresp_msg_err (memresp_msg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: word-array behaviour from plain address arithmetic.
    function automatic void model(input logic t, input logic [31:0] a, input logic [31:0] d,
                                  output logic err, output logic [31:0] rdata);
        int idx;
        idx = int'((a / 4) % N);
`ifdef PLAB2_PROC_DMEM_RESPONDER_ERR_EN
        err = ((a % 4) != 0) || ((a / (4 * N)) != 0);
`else
        err = 1'b0;
`endif
        rdata = 32'h0;
        if (!err) begin
            if (t) begin
                ref_mem[idx] = d;
                written.push_back(idx);
            end else if (ref_mem.exists(idx)) begin
                rdata = ref_mem[idx];
            end
        end
    endfunction

    // Drives one request, observes the response and releases it after `stall` cycles.
    task automatic xact(input logic t, input logic [31:0] a, input logic [31:0] d, input int stall,
                        output int lat, output logic rt, output logic [31:0] rd, output logic re,
                        output logic held, output logic post_rdy, output logic post_val);
        int n;
        lat = -1; rt = 1'b0; rd = 32'h0; re = 1'b0; held = 1'b1; post_rdy = 1'b0; post_val = 1'b1;
        @(negedge clk);
        memreq_val      = 1'b1;
        memreq_msg_type = t;
        memreq_msg_addr = a;
        memreq_msg_data = d;
        n = 0;
        while (!memreq_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!memreq_rdy) begin
            memreq_val = 1'b0;
            return;
        end
        @(negedge clk);
        memreq_val = 1'b0;
        n = 1;
        while (!memresp_val && n < 30) begin
            if (memreq_rdy) held = 1'b0;
            @(negedge clk);
            n++;
        end
        if (!memresp_val) return;
        lat = n;
        rt = memresp_msg_type;
        rd = memresp_msg_data;
        re = memresp_msg_err;
        for (int i = 0; i < stall; i++) begin
            if (memreq_rdy) held = 1'b0;
            @(negedge clk);
            if (!memresp_val || memresp_msg_type !== rt || memresp_msg_data !== rd ||
                memresp_msg_err !== re) held = 1'b0;
        end
        if (memreq_rdy) held = 1'b0;
        memresp_rdy = 1'b1;
        @(negedge clk);
        memresp_rdy = 1'b0;
        post_rdy = memreq_rdy;
        post_val = memresp_val;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (memresp_val !== 1'b0) begin errors++; $display("FAIL reset_val got %0b want 0", memresp_val); end
        checks++;
        if (memresp_msg_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", memresp_msg_data); end
        checks++;
        if (memresp_msg_type !== 1'b0 || memresp_msg_err !== 1'b0) begin
            errors++; $display("FAIL reset_type_err got %0b/%0b want 0/0", memresp_msg_type, memresp_msg_err);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (memreq_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %0b want 1", memreq_rdy); end
    endtask

    task automatic test_write_read();
        int lat; logic rt, re, held, pr, pv, ee; logic [31:0] rd, ed;
        model(1'b1, 32'h1000, 32'hdeadbeef, ee, ed);
        xact(1'b1, 32'h1000, 32'hdeadbeef, 0, lat, rt, rd, re, held, pr, pv);
        checks++;
        if (lat !== int'(LAT + 1) || rt !== 1'b1 || rd !== 32'h0 || re !== ee) begin
            errors++; $display("FAIL wr_resp got lat=%0d t=%0b d=%h e=%0b want lat=%0d t=1 d=0 e=%0b", lat, rt, rd, re, LAT + 1, ee);
        end
        model(1'b0, 32'h1000, 32'h0, ee, ed);
        xact(1'b0, 32'h1000, 32'h0, 0, lat, rt, rd, re, held, pr, pv);
        checks++;
        if (lat !== int'(LAT + 1) || rt !== 1'b0 || rd !== ed || re !== ee) begin
            errors++; $display("FAIL rd_resp got lat=%0d t=%0b d=%h e=%0b want lat=%0d t=0 d=%h e=%0b", lat, rt, rd, re, LAT + 1, ed, ee);
        end
    endtask

    task automatic test_latency();
        int lat; logic rt, re, held, pr, pv, ee; logic [31:0] rd, ed;
        model(1'b1, 32'h0000_0040, 32'h1234_5678, ee, ed);
        xact(1'b1, 32'h0000_0040, 32'h1234_5678, 0, lat, rt, rd, re, held, pr, pv);
        model(1'b0, 32'h0000_0040, 32'h0, ee, ed);
        xact(1'b0, 32'h0000_0040, 32'h0, 0, lat, rt, rd, re, held, pr, pv);
        checks++;
        if (lat !== int'(LAT + 1)) begin errors++; $display("FAIL latency got %0d want %0d", lat, LAT + 1); end
        checks++;
        if (held !== 1'b1) begin errors++; $display("FAIL rdy_low_busy got %0b want 1", held); end
        checks++;
        if (rd !== ed) begin errors++; $display("FAIL latency_data got %h want %h", rd, ed); end
    endtask

    task automatic test_backpressure();
        int lat; logic rt, re, held, pr, pv, ee; logic [31:0] rd, ed;
        model(1'b0, 32'h0000_0040, 32'h0, ee, ed);
        xact(1'b0, 32'h0000_0040, 32'h0, 5, lat, rt, rd, re, held, pr, pv);
        checks++;
        if (held !== 1'b1) begin errors++; $display("FAIL bp_stable got %0b want 1", held); end
        checks++;
        if (pr !== 1'b1 || pv !== 1'b0) begin errors++; $display("FAIL bp_idle got rdy=%0b val=%0b want 1/0", pr, pv); end
        checks++;
        if (rd !== ed) begin errors++; $display("FAIL bp_data got %h want %h", rd, ed); end
    endtask

    task automatic test_alias();
        int lat; logic rt, re, held, pr, pv, ee; logic [31:0] rd, ed;
        model(1'b1, 32'h0000_0004, 32'h11, ee, ed);
        xact(1'b1, 32'h0000_0004, 32'h11, 0, lat, rt, rd, re, held, pr, pv);
        model(1'b0, 32'h0000_0404, 32'h0, ee, ed);
        xact(1'b0, 32'h0000_0404, 32'h0, 0, lat, rt, rd, re, held, pr, pv);
        checks++;
        if (rd !== ed || re !== ee) begin errors++; $display("FAIL alias got d=%h e=%0b want d=%h e=%0b", rd, re, ed, ee); end
    endtask

    task automatic test_reset_in_wait();
        int lat; logic rt, re, held, pr, pv, ee, seen; logic [31:0] rd, ed;
        model(1'b1, 32'h0000_0020, 32'hcafe_f00d, ee, ed);
        xact(1'b1, 32'h0000_0020, 32'hcafe_f00d, 0, lat, rt, rd, re, held, pr, pv);
        @(negedge clk);
        memreq_val = 1'b1; memreq_msg_type = 1'b0; memreq_msg_addr = 32'h0000_0020;
        @(negedge clk);
        memreq_val = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (memreq_rdy !== 1'b1) begin errors++; $display("FAIL rst_wait_rdy got %0b want 1", memreq_rdy); end
        seen = 1'b0;
        memresp_rdy = 1'b1;
        repeat (10) begin
            if (memresp_val) seen = 1'b1;
            @(negedge clk);
        end
        memresp_rdy = 1'b0;
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL rst_wait_noresp got %0b want 0", seen); end
        model(1'b0, 32'h0000_0020, 32'h0, ee, ed);
        xact(1'b0, 32'h0000_0020, 32'h0, 1, lat, rt, rd, re, held, pr, pv);
        checks++;
        if (lat !== int'(LAT + 1) || rd !== ed) begin
            errors++; $display("FAIL rst_wait_after got lat=%0d d=%h want lat=%0d d=%h", lat, rd, LAT + 1, ed);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic rt, re, held, pr, pv, ee; logic [31:0] rd, ed, v, a;
        for (int k = 0; k < 4; k++) begin
            v = $urandom;
            a = 32'($urandom_range(0, N - 1)) << 2;
            model(1'b1, a, v, ee, ed);
            xact(1'b1, a, v, 0, lat, rt, rd, re, held, pr, pv);
            model(1'b0, a, 32'h0, ee, ed);
            xact(1'b0, a, 32'h0, 0, lat, rt, rd, re, held, pr, pv);
            checks++;
            if (rd !== ed || rd !== v) begin errors++; $display("FAIL b2b[%0d] got %h want %h", k, rd, v); end
        end
    endtask

    task automatic test_random();
        int lat; logic rt, re, held, pr, pv, ee, t; logic [31:0] rd, ed, d, a, junk;
        for (int k = 0; k < 200; k++) begin
            t = (written.size() == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (t) a = 32'($urandom_range(0, N - 1)) << 2;
            else   a = 32'(written[$urandom_range(0, written.size() - 1)]) << 2;
            junk = $urandom & ~(32'(N - 1) << 2);
            if ($urandom_range(0, 5) == 0) a = a | junk;
            d = $urandom;
            model(t, a, d, ee, ed);
            xact(t, a, d, $urandom_range(0, 3), lat, rt, rd, re, held, pr, pv);
            checks++;
            if (lat !== int'(LAT + 1) || held !== 1'b1) begin
                errors++; $display("FAIL rnd_timing[%0d] got lat=%0d held=%0b want lat=%0d held=1", k, lat, held, LAT + 1);
            end
            checks++;
            if (rt !== t || rd !== ed || re !== ee) begin
                errors++; $display("FAIL rnd_payload[%0d] a=%h got t=%0b d=%h e=%0b want t=%0b d=%h e=%0b", k, a, rt, rd, re, t, ed, ee);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        memreq_val = 1'b0;
        memreq_msg_type = 1'b0;
        memreq_msg_addr = 32'h0;
        memreq_msg_data = 32'h0;
        memresp_rdy = 1'b0;
        test_reset();
        test_write_read();
        test_latency();
        test_backpressure();
        test_alias();
        test_reset_in_wait();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
